// File: rtl/priority_decoder_4_12_seq_if.sv
// Handshake and request-bus bundle between a code source and the 4-to-12 sequenced decoder.
// Master presents codes; slave accepts them and drives the one-hot request bus.
interface priority_decoder_4_12_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  code;
    logic [11:0] r;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output in_valid, code,
        input  in_ready, r, busy, done, err
    );

    modport slave (
        input  in_valid, code,
        output in_ready, r, busy, done, err
    );
endinterface

// File: rtl/priority_decoder_4_12_seq.sv
// Sequenced 4-to-12 decoder: each code 1..12 holds its one-hot line on r for HOLD_CYCLES cycles.
// Latency 1 cycle from acceptance to r; one pending slot gives gapless back-to-back codes;
// in_ready drops only while the pending slot is full.
module priority_decoder_4_12_seq #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    priority_decoder_4_12_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             LOAD_IS_LAST = (HOLD_CYCLES == 1);

    typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend_vld;
    logic [3:0]       pend_code;
    logic [11:0]      r_q;
    logic             done_q;
    logic             err_q;

    logic accept;
    logic code_ok;
    logic code_ill;

    function automatic logic [11:0] onehot(input logic [3:0] c);
        logic [11:0] base;
        base   = 12'h001;
        onehot = base << (c - 4'd1);
    endfunction

    assign accept   = bus.in_valid && !pend_vld;
    assign code_ok  = (bus.code != 4'd0) && (bus.code <= 4'd12);
    assign code_ill = (bus.code >= 4'd13);

    // done is registered, so it is raised on the edge that makes the counter reach zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_vld  <= 1'b0;
            pend_code <= 4'd0;
            r_q       <= 12'h000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= accept && code_ill;
            case (state)
                IDLE: begin
                    if (accept && code_ok) begin
                        state  <= DRIVE;
                        r_q    <= onehot(bus.code);
                        cnt    <= CNT_LOAD;
                        done_q <= LOAD_IS_LAST;
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt    <= cnt - CNT_ONE;
                        done_q <= (cnt == CNT_ONE);
                        if (accept && code_ok) begin
                            pend_vld  <= 1'b1;
                            pend_code <= bus.code;
                        end
                    end else if (pend_vld) begin
                        r_q      <= onehot(pend_code);
                        cnt      <= CNT_LOAD;
                        done_q   <= LOAD_IS_LAST;
                        pend_vld <= 1'b0;
                    end else if (accept && code_ok) begin
                        r_q    <= onehot(bus.code);
                        cnt    <= CNT_LOAD;
                        done_q <= LOAD_IS_LAST;
                    end else begin
                        state <= IDLE;
                        r_q   <= 12'h000;
                    end
                end
                default: begin
                    state <= IDLE;
                    r_q   <= 12'h000;
                end
            endcase
        end
    end

    assign bus.in_ready = !pend_vld;
    assign bus.r        = r_q;
    assign bus.busy     = (state == DRIVE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_priority_decoder_4_12_seq.sv
// Directed-vector bench for priority_decoder_4_12_seq at HOLD_CYCLES=4 and HOLD_CYCLES=1,
// including a loopback through a reference 12-to-4 priority encoder.
module tb_priority_decoder_4_12_seq;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    priority_decoder_4_12_seq_if m4 ();
    priority_decoder_4_12_seq_if m1 ();

    priority_decoder_4_12_seq #(.HOLD_CYCLES(4)) u_dut4 (.clk(clk), .reset(reset), .bus(m4));
    priority_decoder_4_12_seq #(.HOLD_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(m1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] t2_r    [0:12];
    logic        t2_done [0:12];
    logic        t2_rdy  [0:12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [11:0] er, input logic eb,
                        input logic ed, input logic ee, input logic erdy);
        chk({tag, ".r"},        m4.r,                er);
        chk({tag, ".busy"},     {11'd0, m4.busy},     {11'd0, eb});
        chk({tag, ".done"},     {11'd0, m4.done},     {11'd0, ed});
        chk({tag, ".err"},      {11'd0, m4.err},      {11'd0, ee});
        chk({tag, ".in_ready"}, {11'd0, m4.in_ready}, {11'd0, erdy});
    endtask

    // Reference 12-to-4 priority encoder: highest set bit wins, 0 when nothing is set
    function automatic logic [3:0] penc(input logic [11:0] v);
        logic [3:0] p;
        p = 4'd0;
        for (int i = 0; i < 12; i++) if (v[i]) p = 4'(i + 1);
        return p;
    endfunction

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        m4.in_valid = 1'b0; m4.code = 4'd0;
        m1.in_valid = 1'b0; m1.code = 4'd0;

        t2_r    = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h001, 12'h001, 12'h001,
                    12'h001, 12'h010, 12'h010, 12'h010, 12'h010, 12'h000};
        t2_done = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        t2_rdy  = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};

        #3;
        chk4("reset", 12'h000, 0, 0, 0, 1);
        chk("reset1.r", m1.r, 12'h000);
        #9 reset = 1'b0;
        tick();

        // Single code 3
        m4.in_valid = 1'b1; m4.code = 4'd3;
        tick();
        m4.in_valid = 1'b0;
        chk4("c3.h0", 12'h004, 1, 0, 0, 1);
        tick(); chk4("c3.h1", 12'h004, 1, 0, 0, 1);
        tick(); chk4("c3.h2", 12'h004, 1, 0, 0, 1);
        tick(); chk4("c3.h3", 12'h004, 1, 1, 0, 1);
        tick(); chk4("c3.end", 12'h000, 0, 0, 0, 1);

        // Back-to-back 12, 1, 5 with in_valid held
        m4.in_valid = 1'b1; m4.code = 4'd12;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk4($sformatf("b2b[%0d]", i), t2_r[i], (i != 12), t2_done[i], 0, t2_rdy[i]);
            if (i == 0) m4.code = 4'd1;
            if (i == 1) m4.code = 4'd5;
            if (i == 5) m4.in_valid = 1'b0;
        end

        // Illegal codes: 13 in idle, 15 during drive of code 2
        m4.in_valid = 1'b1; m4.code = 4'hD;
        tick(); m4.in_valid = 1'b0;
        chk4("illD", 12'h000, 0, 0, 1, 1);
        tick(); chk4("illD.after", 12'h000, 0, 0, 0, 1);
        m4.in_valid = 1'b1; m4.code = 4'd2;
        tick(); m4.code = 4'hF;
        chk4("c2.h0", 12'h002, 1, 0, 0, 1);
        tick(); m4.in_valid = 1'b0;
        chk4("illF", 12'h002, 1, 0, 1, 1);
        tick(); chk4("c2.h2", 12'h002, 1, 0, 0, 1);
        tick(); chk4("c2.h3", 12'h002, 1, 1, 0, 1);
        tick(); chk4("c2.end", 12'h000, 0, 0, 0, 1);

        // Null code in idle and during drive of code 7
        m4.in_valid = 1'b1; m4.code = 4'd0;
        tick(); chk4("null.idle", 12'h000, 0, 0, 0, 1);
        m4.code = 4'd7;
        tick(); m4.code = 4'd0;
        chk4("c7.h0", 12'h040, 1, 0, 0, 1);
        tick(); m4.in_valid = 1'b0;
        chk4("null.drive", 12'h040, 1, 0, 0, 1);
        tick(); chk4("c7.h2", 12'h040, 1, 0, 0, 1);
        tick(); chk4("c7.h3", 12'h040, 1, 1, 0, 1);
        tick(); chk4("c7.end", 12'h000, 0, 0, 0, 1);

        // Reset mid-drive of code 9 with code 10 pending
        m4.in_valid = 1'b1; m4.code = 4'd9;
        tick(); m4.code = 4'd10;
        chk4("c9.h0", 12'h100, 1, 0, 0, 1);
        tick(); m4.in_valid = 1'b0;
        chk4("c9.pend", 12'h100, 1, 0, 0, 0);
        #2 reset = 1'b1;
        #1 chk4("rst.mid", 12'h000, 0, 0, 0, 1);
        #1 reset = 1'b0;
        tick(); chk4("rst.after", 12'h000, 0, 0, 0, 1);
        m4.in_valid = 1'b1; m4.code = 4'd6;
        tick(); m4.in_valid = 1'b0;
        chk4("c6.h0", 12'h020, 1, 0, 0, 1);
        tick(); chk4("c6.h1", 12'h020, 1, 0, 0, 1);
        tick(); chk4("c6.h2", 12'h020, 1, 0, 0, 1);
        tick(); chk4("c6.h3", 12'h020, 1, 1, 0, 1);
        tick(); chk4("c6.end", 12'h000, 0, 0, 0, 1);
        tick(); chk4("c6.idle", 12'h000, 0, 0, 0, 1);

        // Loopback through the encoder, HOLD_CYCLES=4
        for (int c = 1; c <= 12; c++) begin
            m4.in_valid = 1'b1; m4.code = 4'(c);
            tick(); m4.in_valid = 1'b0;
            for (int h = 0; h < 4; h++) begin
                chk($sformatf("lb4.c%0d.h%0d", c, h), {8'd0, penc(m4.r)}, 12'(c));
                tick();
            end
            chk($sformatf("lb4.c%0d.idle", c), {8'd0, penc(m4.r)}, 12'd0);
        end

        // Loopback, HOLD_CYCLES=1, with idle gaps
        for (int c = 1; c <= 12; c++) begin
            m1.in_valid = 1'b1; m1.code = 4'(c);
            tick(); m1.in_valid = 1'b0;
            chk($sformatf("lb1.c%0d", c), {8'd0, penc(m1.r)}, 12'(c));
            chk($sformatf("lb1.c%0d.done", c), {11'd0, m1.done}, 12'd1);
            tick();
            chk($sformatf("lb1.c%0d.idle", c), {8'd0, penc(m1.r)}, 12'd0);
        end

        // HOLD_CYCLES=1 continuous stream: a new code accepted every cycle
        m1.in_valid = 1'b1; m1.code = 4'd1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            m1.code = 4'((c % 12) + 1);
            if (c == 12) m1.in_valid = 1'b0;
            chk($sformatf("str1.c%0d.r", c), m1.r, 12'h001 << (c - 1));
            chk($sformatf("str1.c%0d.done", c), {11'd0, m1.done}, 12'd1);
            chk($sformatf("str1.c%0d.rdy", c), {11'd0, m1.in_ready}, 12'd1);
        end
        tick();
        chk("str1.end", m1.r, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/priority_decoder_4_12_seq.md
Name: priority_decoder_4_12_seq

Overview:
Sequenced inverse of the 12-to-4 priority encoder. Accepts 4-bit request codes (1..12 valid, 0 = null, 13..15 illegal) over a valid/ready handshake. Drives the matching one-hot line on a 12-bit request bus for a fixed number of cycles. A one-entry pending buffer allows back-to-back codes with no gap. Sits upstream of the priority encoder, as stimulus generator and request replayer.

Parameters:
HOLD_CYCLES, 4, cycles each valid code's one-hot line is held (must be >= 1)
CNT_W, $clog2(HOLD_CYCLES+1), width of hold counter (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  code presented on code
in_ready  output  1  block can accept a code this cycle
code  input  4  request code: 0 null, 1..12 valid, 13..15 illegal
r  output  12  registered one-hot request bus; bit c-1 for code c
busy  output  1  high while a code is being driven
done  output  1  one-cycle pulse on the final hold cycle of each code
err  output  1  one-cycle pulse, cycle after an illegal code is accepted

Behaviour:
- Reset (async, active-high): state IDLE, pending empty, counter 0, r=0, busy=0, done=0, err=0. Takes effect immediately, mid-drive included. The pending code is discarded.
- Handshake: transfer occurs on the rising edge with in_valid && in_ready. in_ready = pending buffer empty (combinational from a register). It does not depend on in_valid.
- Code classification at acceptance:
  - 0: consumed, no other effect.
  - 13..15: consumed, err=1 the following cycle. Never stored, never driven.
  - 1..12: goes to drive if IDLE, else to the pending buffer.
- FSM states IDLE and DRIVE:
  - IDLE, valid code c accepted: next cycle DRIVE, r = 1 << (c-1), counter = HOLD_CYCLES-1.
  - DRIVE, counter > 0: decrement, r held.
  - DRIVE, counter == 0: done=1 this cycle (final hold cycle).
    - If pending full: next cycle r = one-hot of pending code, counter reloaded, pending cleared. No idle gap.
    - Else if a valid code is accepted this same cycle: it drives directly next cycle, also no gap.
    - Else: next cycle IDLE, r=0.
- Latency: acceptance edge to r asserted is 1 cycle. Each code occupies exactly HOLD_CYCLES cycles on r.
- Outputs: r is always one-hot or zero, never multi-hot. busy = (state == DRIVE).
- Pending full: in_ready=0 until the cycle after the pending code moves into drive. in_valid is ignored while in_ready=0, and code must not be sampled.
- HOLD_CYCLES=1: each code drives r for one cycle. done is high every drive cycle. Back-to-back codes produce a continuous one-hot stream.
- Simultaneous events:
  - Illegal or zero code accepted while DRIVE: r, counter and pending are unaffected. err pulses as normal.
  - Acceptance on the final hold cycle with pending empty: the new code drives directly next cycle. It does not enter pending.
- All outputs are registered. No combinational path from code or in_valid to r, done or err.

Test Plan:
- HOLD_CYCLES=4, reset released, code=3 accepted -> r=12'h004 for 4 cycles starting 1 cycle after acceptance; done high on the 4th; busy high for those 4; then r=0, busy=0.
- Codes 12, 1, 5 presented back-to-back with in_valid held -> r=12'h800 x4 then 12'h001 x4 then 12'h010 x4, no gap. in_ready low while pending holds 1, and again while it holds 5. Exactly 3 done pulses.
- code=4'hD accepted in IDLE, then code=4'hF accepted mid-drive of code 2 -> err pulses once for each, cycle after acceptance. r stays 0 for the first; code 2's 12'h002 is undisturbed for the second.
- code=0 accepted in IDLE and during DRIVE -> no change to r, busy, done or err; in_ready stays 1.
- reset asserted mid-drive with pending full -> r=0, busy=0, in_ready=1 immediately. After release, the next code drives normally and the old pending code never appears.
- Loopback: r fed into the 12-to-4 priority encoder, codes 1..12 in order -> encoder output equals each accepted code for HOLD_CYCLES cycles, 0 when idle. Repeat with HOLD_CYCLES=1.
